// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares the single TX FIFO write port between NumReq requesters. Whole
//   messages (framed by i_req_last) are granted round-robin, so bytes from
//   different requesters never interleave on the serial line.
//
//   Ports:
//     i_clk, i_rst          clock, synchronous active-high reset
//     i_req_valid/_data/_last  per-requester byte stream (data packed k*DataLength)
//     o_req_ready           per-requester accept (valid && ready = transfer)
//     o_tx_fifo_data/_write_en  FIFO write port, i_tx_fifo_full back-pressure
//     o_grant               one-hot current owner, zero when idle
//     o_busy                high while a message is in progress
//     o_timeout             one-cycle pulse when a stalled grant is revoked
//
//   Optional feature: define UART_TX_ARB_TIMEOUT_EN to revoke a grant after
//   TimeoutCycles cycles without a transfer. Without it o_timeout is tied 0
//   and the grant is held until the owner's last byte.
module uart_tx_arbiter #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned DataLength    = 8,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NumReq-1:0]            i_req_valid,
  input  logic [NumReq*DataLength-1:0] i_req_data,
  input  logic [NumReq-1:0]            i_req_last,
  output logic [NumReq-1:0]            o_req_ready,
  output logic [DataLength-1:0]        o_tx_fifo_data,
  output logic                         o_tx_fifo_write_en,
  input  logic                         i_tx_fifo_full,
  output logic [NumReq-1:0]            o_grant,
  output logic                         o_busy,
  output logic                         o_timeout
);

  localparam int unsigned IdxW = $clog2(NumReq);

  if (NumReq < 2 || NumReq > 16) begin : g_bad_numreq
    $error("uart_tx_arbiter: NumReq must be in 2..16");
  end
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TimeoutCycles must be >= 2");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   last_grant_q, last_grant_d;
  logic [NumReq-1:0] grant_q, grant_d;
  logic              busy_q, busy_d;

  logic              xfer;
  logic              stall_expired;
  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   cand_idx;

  // A byte moves when the owner is valid and the FIFO has room.
  assign xfer = (state_q == XFER) && i_req_valid[owner_q] && !i_tx_fifo_full;

  // Round-robin pick: first valid requester scanning up from last_grant+1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand_idx = IdxW'((32'(last_grant_q) + i) % NumReq);
      if (!win_found && i_req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] stall_q, stall_d;
  logic            timeout_q, timeout_d;

  assign stall_expired = (state_q == XFER) && !xfer &&
                         (stall_q == CntW'(TimeoutCycles - 1));

  // Counter is held at zero outside XFER so it starts clean on every grant.
  always_comb begin
    stall_d = '0;
    if (state_q == XFER && !xfer) begin
      stall_d = stall_q + CntW'(1);
    end
  end

  assign timeout_d = stall_expired;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign stall_expired = 1'b0;
  assign o_timeout     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          owner_d          = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          busy_d           = 1'b1;
          state_d          = XFER;
        end
      end
      XFER: begin
        if ((xfer && i_req_last[owner_q]) || stall_expired) begin
          last_grant_d = owner_q;
          grant_d      = '0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= IdxW'(NumReq - 1);
      grant_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
    end
  end

  // FIFO-side outputs follow the registered owner combinationally so a
  // held byte is written in the first non-full cycle.
  always_comb begin
    o_req_ready        = '0;
    o_tx_fifo_write_en = 1'b0;
    o_tx_fifo_data     = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (owner_q == IdxW'(k)) begin
        o_tx_fifo_data = i_req_data[k*DataLength +: DataLength];
      end
    end
    if (state_q == XFER) begin
      o_req_ready[owner_q] = !i_tx_fifo_full;
      o_tx_fifo_write_en   = xfer;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = busy_q;

endmodule
